fetch_pc_gen: RTL and testbench

FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

---
 rtl/fetch_pc_gen_if.sv | 39 +++
 rtl/fetch_pc_gen.sv | 124 ++++++++++++
 tb/tb_fetch_pc_gen.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_gen_if
// Brief    : Handshake and bus signals between the fetch PC generator, the
//            instruction memory, the predecoder and the instruction queue.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_pc_gen_if;
    logic        mispredict;
    logic [31:0] mispredict_target;
    logic        bp_valid;
    logic [31:0] bp_target;
    logic        iq_full;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] instruction;
    logic [31:0] pc_late;
    logic        iq_push;
    logic [15:0] drop_count;

    // Fetch unit side
    modport master (
        input  mispredict, mispredict_target, bp_valid, bp_target,
               iq_full, imem_resp, imem_rdata,
        output imem_addr, imem_rmask, instruction, pc_late, iq_push,
               drop_count
    );

    // Environment side (memory, predecoder, queue, backend)
    modport slave (
        output mispredict, mispredict_target, bp_valid, bp_target,
               iq_full, imem_resp, imem_rdata,
        input  imem_addr, imem_rmask, instruction, pc_late, iq_push,
               drop_count
    );
endinterface
`default_nettype wire

// File: rtl/fetch_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_gen
// Brief    : Fetch PC generator. Issues one instruction-memory request at a
//            time, forwards the response to the queue in the same cycle, and
//            discards responses made stale by a backend mispredict.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
    input  wire            clk,
    input  wire            rst,
    fetch_pc_gen_if.master bus
);

    // ISSUE: no request outstanding. WAIT: request outstanding, response
    // wanted. DROP: request outstanding, response to be discarded.
    localparam logic [1:0] S_ISSUE = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DROP  = 2'd2;

    localparam logic [15:0] C_DROP_MAX = 16'hffff;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [15:0] r_drop_count;

    logic [1:0]  w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [15:0] w_drop_nxt;
    logic        w_drop_inc;
    logic        w_req;
    logic        w_push;

    // State register; reset abandons any outstanding request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_ISSUE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, next PC and request/push decode; mispredict always wins
    // over the predecode redirect, which wins over sequential fetch.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_drop_inc  = 1'b0;
        w_req       = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            S_ISSUE: begin
                if (bus.mispredict) begin
                    w_pc_nxt = bus.mispredict_target;
                end else if (!bus.iq_full) begin
                    w_req       = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.imem_resp) begin
                    w_state_nxt = S_ISSUE;
                    if (bus.mispredict) begin
                        w_pc_nxt   = bus.mispredict_target;
                        w_drop_inc = 1'b1;
                    end else begin
                        w_push   = 1'b1;
                        w_pc_nxt = bus.bp_valid ? bus.bp_target : (r_pc + 32'd4);
                    end
                end else if (bus.mispredict) begin
                    w_pc_nxt    = bus.mispredict_target;
                    w_state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (bus.imem_resp) begin
                    w_drop_inc  = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
                if (bus.mispredict) begin
                    w_pc_nxt = bus.mispredict_target;
                end
            end
            default: begin
                w_state_nxt = S_ISSUE;
            end
        endcase
    end

    // Saturating count of discarded responses.
    always_comb begin
        w_drop_nxt = r_drop_count;
        if (w_drop_inc && (r_drop_count != C_DROP_MAX)) begin
            w_drop_nxt = r_drop_count + 16'd1;
        end
    end

    // PC and drop counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_drop_count <= 16'd0;
        end else begin
            r_pc         <= w_pc_nxt;
            r_drop_count <= w_drop_nxt;
        end
    end

    // Outputs: request and push are gated by rst so nothing leaks out while
    // reset is held; instruction reads as zero when not pushing so the
    // predecoder never sees a branch opcode.
    always_comb begin
        bus.imem_addr   = r_pc;
        bus.pc_late     = r_pc;
        bus.imem_rmask  = (w_req && !rst) ? 4'hf : 4'h0;
        bus.iq_push     = w_push && !rst;
        bus.instruction = (w_push && !rst) ? bus.imem_rdata : 32'h0;
        bus.drop_count  = r_drop_count;
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_pc_gen
// Brief    : Self-checking bench for fetch_pc_gen: directed vector table,
//            asynchronous reset sequence and randomized traffic against a
//            request/response reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_gen;

    localparam logic [31:0] C_RESET_PC = 32'h1eceb000;

    logic clk;
    logic rst;

    fetch_pc_gen_if bus();

    fetch_pc_gen #(.RESET_PC(C_RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic        mp;
        logic [31:0] mpt;
        logic        bpv;
        logic [31:0] bpt;
        logic        full;
        logic        resp;
        logic [31:0] rdata;
        logic [31:0] e_addr;
        logic [3:0]  e_rmask;
        logic        e_push;
        logic [31:0] e_instr;
        logic [15:0] e_drop;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic mp, input logic [31:0] mpt,
                                input logic bpv, input logic [31:0] bpt,
                                input logic full, input logic resp,
                                input logic [31:0] rdata, input logic [31:0] ea,
                                input logic [3:0] er, input logic ep,
                                input logic [31:0] ei, input logic [15:0] ed);
        vec_t v;
        v.mp = mp; v.mpt = mpt; v.bpv = bpv; v.bpt = bpt; v.full = full;
        v.resp = resp; v.rdata = rdata; v.e_addr = ea; v.e_rmask = er;
        v.e_push = ep; v.e_instr = ei; v.e_drop = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [31:0] e_addr,
                                 input logic [3:0] e_rmask, input logic e_push,
                                 input logic [31:0] e_instr, input logic [15:0] e_drop);
        chk({tag, ".imem_addr"},   bus.imem_addr,        e_addr);
        chk({tag, ".pc_late"},     bus.pc_late,          e_addr);
        chk({tag, ".imem_rmask"},  32'(bus.imem_rmask),  32'(e_rmask));
        chk({tag, ".iq_push"},     32'(bus.iq_push),     32'(e_push));
        chk({tag, ".instruction"}, bus.instruction,      e_instr);
        chk({tag, ".drop_count"},  32'(bus.drop_count),  32'(e_drop));
    endtask

    task automatic drive(input logic mp, input logic [31:0] mpt, input logic bpv,
                         input logic [31:0] bpt, input logic full, input logic resp,
                         input logic [31:0] rdata);
        bus.mispredict        = mp;
        bus.mispredict_target = mpt;
        bus.bp_valid          = bpv;
        bus.bp_target         = bpt;
        bus.iq_full           = full;
        bus.imem_resp         = resp;
        bus.imem_rdata        = rdata;
    endtask

    function automatic logic [31:0] pick_target();
        logic [31:0] t;
        t = $urandom();
        t[1:0] = 2'b00;
        if ($urandom_range(0, 3) == 0) t = 32'hfffffffc;
        return t;
    endfunction

    // reference model state: PC, whether a request is outstanding, whether
    // its response is already doomed, and the discard count
    logic [31:0] m_pc;
    logic        m_out;
    logic        m_doom;
    logic [15:0] m_drops;
    logic        mem_busy;
    int          mem_cnt;

    initial begin
        logic        mp, bpv, full, resp, e_req, e_push;
        logic [31:0] mpt, bpt, rdata;

        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        // reset held across a clock edge, iq_full low
        #12;
        check_outputs("reset", C_RESET_PC, 4'h0, 1'b0, 32'h0, 16'h0);

        @(negedge clk);
        rst = 1'b0;

        // directed vectors, one row per cycle starting at reset release
        tbl.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h1eceb000, 4'hf, 1'b0, 32'h0,        16'd0));
        tbl.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h1eceb000, 4'h0, 1'b0, 32'h0,        16'd0));
        tbl.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h11111111, 32'h1eceb000, 4'h0, 1'b1, 32'h11111111, 16'd0));
        tbl.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h1eceb004, 4'hf, 1'b0, 32'h0,        16'd0));
        tbl.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h1eceb004, 4'h0, 1'b0, 32'h0,        16'd0));
        tbl.push_back(mk(1'b0, 32'h0,        1'b1, 32'h1eceb100, 1'b0, 1'b1, 32'h22222222, 32'h1eceb004, 4'h0, 1'b1, 32'h22222222, 16'd0));
        tbl.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h1eceb100, 4'hf, 1'b0, 32'h0,        16'd0));
        tbl.push_back(mk(1'b1, 32'h1eceb200, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h1eceb100, 4'h0, 1'b0, 32'h0,        16'd0));
        tbl.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h33333333, 32'h1eceb200, 4'h0, 1'b0, 32'h0,        16'd0));
        tbl.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h1eceb200, 4'hf, 1'b0, 32'h0,        16'd1));
        tbl.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h1eceb200, 4'h0, 1'b0, 32'h0,        16'd1));
        tbl.push_back(mk(1'b1, 32'h1eceb400, 1'b1, 32'h1eceb300, 1'b0, 1'b1, 32'h44444444, 32'h1eceb200, 4'h0, 1'b0, 32'h0,        16'd1));
        tbl.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h1eceb400, 4'hf, 1'b0, 32'h0,        16'd2));
        tbl.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h1eceb400, 4'h0, 1'b0, 32'h0,        16'd2));
        tbl.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'h55555555, 32'h1eceb400, 4'h0, 1'b1, 32'h55555555, 16'd2));
        tbl.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h1eceb404, 4'h0, 1'b0, 32'h0,        16'd2));
        tbl.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'hdeadbeef, 32'h1eceb404, 4'h0, 1'b0, 32'h0,        16'd2));
        tbl.push_back(mk(1'b0, 32'h0,        1'b1, 32'h0badc0de, 1'b1, 1'b0, 32'h0,        32'h1eceb404, 4'h0, 1'b0, 32'h0,        16'd2));
        tbl.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h1eceb404, 4'h0, 1'b0, 32'h0,        16'd2));
        tbl.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h1eceb404, 4'h0, 1'b0, 32'h0,        16'd2));
        tbl.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h1eceb404, 4'hf, 1'b0, 32'h0,        16'd2));
        tbl.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h66666666, 32'h1eceb404, 4'h0, 1'b1, 32'h66666666, 16'd2));
        tbl.push_back(mk(1'b1, 32'h1eceb500, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h1eceb408, 4'h0, 1'b0, 32'h0,        16'd2));
        tbl.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h1eceb500, 4'hf, 1'b0, 32'h0,        16'd2));
        tbl.push_back(mk(1'b1, 32'h1eceb600, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h1eceb500, 4'h0, 1'b0, 32'h0,        16'd2));
        tbl.push_back(mk(1'b1, 32'h1eceb700, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h1eceb600, 4'h0, 1'b0, 32'h0,        16'd2));
        tbl.push_back(mk(1'b1, 32'h1eceb800, 1'b0, 32'h0,        1'b0, 1'b1, 32'h77777777, 32'h1eceb700, 4'h0, 1'b0, 32'h0,        16'd2));
        tbl.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h1eceb800, 4'hf, 1'b0, 32'h0,        16'd3));
        tbl.push_back(mk(1'b1, 32'hfffffffc, 1'b0, 32'h0,        1'b0, 1'b1, 32'h88888888, 32'h1eceb800, 4'h0, 1'b0, 32'h0,        16'd3));
        tbl.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'hfffffffc, 4'hf, 1'b0, 32'h0,        16'd4));
        tbl.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'hfffffffc, 4'h0, 1'b0, 32'h0,        16'd4));
        tbl.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h99999999, 32'hfffffffc, 4'h0, 1'b1, 32'h99999999, 16'd4));
        tbl.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h00000000, 4'hf, 1'b0, 32'h0,        16'd4));
        tbl.push_back(mk(1'b1, 32'h1eceb700, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h00000000, 4'h0, 1'b0, 32'h0,        16'd4));

        foreach (tbl[i]) begin
            drive(tbl[i].mp, tbl[i].mpt, tbl[i].bpv, tbl[i].bpt, tbl[i].full, tbl[i].resp, tbl[i].rdata);
            #1;
            check_outputs($sformatf("row%0d", i), tbl[i].e_addr, tbl[i].e_rmask, tbl[i].e_push, tbl[i].e_instr, tbl[i].e_drop);
            @(negedge clk);
        end

        // now in DROP with a request outstanding; assert reset mid-cycle
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        check_outputs("drop_hold", 32'h1eceb700, 4'h0, 1'b0, 32'h0, 16'd4);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_outputs("async_rst", C_RESET_PC, 4'h0, 1'b0, 32'h0, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_outputs("rst_release", C_RESET_PC, 4'hf, 1'b0, 32'h0, 16'd0);

        // randomized traffic from the same reset-released point
        m_pc = C_RESET_PC; m_out = 1'b0; m_doom = 1'b0; m_drops = 16'd0;
        mem_busy = 1'b0; mem_cnt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            mp    = ($urandom_range(0, 7) == 0);
            mpt   = pick_target();
            bpv   = ($urandom_range(0, 2) == 0);
            bpt   = pick_target();
            full  = ($urandom_range(0, 3) == 0);
            rdata = $urandom();
            if (mem_busy) resp = (mem_cnt == 0);
            else          resp = ($urandom_range(0, 9) == 0);
            drive(mp, mpt, bpv, bpt, full, resp, rdata);
            #1;
            e_req  = !m_out && !mp && !full;
            e_push = m_out && !m_doom && resp && !mp;
            check_outputs($sformatf("rnd%0d", cyc), m_pc, e_req ? 4'hf : 4'h0, e_push,
                          e_push ? rdata : 32'h0, m_drops);
            @(posedge clk);
            if (!m_out) begin
                if (mp)        m_pc = mpt;
                else if (!full) begin m_out = 1'b1; m_doom = 1'b0; end
            end else if (resp) begin
                if (m_doom || mp) begin
                    if (m_drops != 16'hffff) m_drops = m_drops + 16'd1;
                end
                if (mp)          m_pc = mpt;
                else if (!m_doom) m_pc = bpv ? bpt : m_pc + 32'd4;
                m_out = 1'b0;
            end else if (mp) begin
                m_pc   = mpt;
                m_doom = 1'b1;
            end
            if (mem_busy) begin
                if (mem_cnt == 0) mem_busy = 1'b0;
                else              mem_cnt--;
            end
            if (e_req) begin
                mem_busy = 1'b1;
                mem_cnt  = $urandom_range(0, 2);
            end
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
